// File: rtl/axis_pkt_mux2_pkg.sv
// Shared types and defaults for the 2:1 AXI-Stream packet multiplexer.
package axis_pkt_mux2_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  // Arbiter state: idle (arbitration bubble) or passing one source's packet.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS0 = 2'd1,
    PASS1 = 2'd2
  } state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Output register slice: holds one beat (data, last, id) and its valid flag.
module axis_out_reg
  import axis_pkt_mux2_pkg::*;
#(
  parameter int unsigned DataWidth = DEF_DATA_WIDTH
) (
  input  logic                 counter_clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_last,
  input  logic                 in_id,
  input  logic                 m_tready,
  output logic [DataWidth-1:0] m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  output logic                 m_tid,
  output logic                 load_en_c
);

  // Slot can take a new beat when empty or when its current beat drains this cycle.
  assign load_en_c = !m_tvalid || m_tready;

  // Load a new beat, or drop valid once the held beat is taken; payload holds otherwise.
  always_ff @(posedge counter_clk or posedge reset) begin
    if (reset) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tid    <= 1'b0;
    end else if (load) begin
      m_tdata  <= in_data;
      m_tvalid <= 1'b1;
      m_tlast  <= in_last;
      m_tid    <= in_id;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_pkt_mux2.sv
// 2:1 AXI-Stream packet mux: round-robin at packet boundaries, registered output,
// per-source completed-packet counters.
module axis_pkt_mux2
  import axis_pkt_mux2_pkg::*;
#(
  parameter int unsigned DataWidth = DEF_DATA_WIDTH,
  parameter int unsigned CntWidth  = DEF_CNT_WIDTH
) (
  input  logic                 counter_clk,
  input  logic                 reset,
  input  logic [DataWidth-1:0] s0_tdata,
  input  logic                 s0_tvalid,
  input  logic                 s0_tlast,
  output logic                 s0_tready,
  input  logic [DataWidth-1:0] s1_tdata,
  input  logic                 s1_tvalid,
  input  logic                 s1_tlast,
  output logic                 s1_tready,
  output logic [DataWidth-1:0] m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  output logic                 m_tid,
  input  logic                 m_tready,
  output logic [CntWidth-1:0]  pkt_cnt0,
  output logic [CntWidth-1:0]  pkt_cnt1
);

  state_t               state_q;
  state_t               state_d;
  logic                 last_grant_q;
  logic                 load_en;
  logic                 beat;
  logic                 beat_id;
  logic                 beat_last;
  logic [DataWidth-1:0] beat_data;

  // Arbitration and beat acceptance; tready depends only on grant and output space.
  always_comb begin
    state_d   = state_q;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    beat      = 1'b0;
    beat_id   = 1'b0;
    beat_data = s0_tdata;
    beat_last = s0_tlast;
    case (state_q)
      IDLE: begin
        if (s0_tvalid && s1_tvalid) begin
          state_d = last_grant_q ? PASS0 : PASS1;
        end else if (s0_tvalid) begin
          state_d = PASS0;
        end else if (s1_tvalid) begin
          state_d = PASS1;
        end
      end
      PASS0: begin
        s0_tready = load_en;
        if (s0_tvalid && load_en) begin
          beat = 1'b1;
          if (s0_tlast) state_d = IDLE;
        end
      end
      PASS1: begin
        s1_tready = load_en;
        beat_id   = 1'b1;
        beat_data = s1_tdata;
        beat_last = s1_tlast;
        if (s1_tvalid && load_en) begin
          beat = 1'b1;
          if (s1_tlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin pointer and packet counters advance on the tlast acceptance edge.
  always_ff @(posedge counter_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      pkt_cnt0     <= '0;
      pkt_cnt1     <= '0;
    end else begin
      state_q <= state_d;
      if (beat && beat_last) begin
        last_grant_q <= beat_id;
        if (beat_id) pkt_cnt1 <= pkt_cnt1 + CntWidth'(1);
        else         pkt_cnt0 <= pkt_cnt0 + CntWidth'(1);
      end
    end
  end

  axis_out_reg #(
    .DataWidth (DataWidth)
  ) u_out_reg (
    .counter_clk (counter_clk),
    .reset       (reset),
    .load        (beat),
    .in_data     (beat_data),
    .in_last     (beat_last),
    .in_id       (beat_id),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tid       (m_tid),
    .load_en_c   (load_en)
  );

endmodule

// File: doc/axis_pkt_mux2.md
Name: axis_pkt_mux2

Overview:
- 2:1 AXI-Stream packet multiplexer.
- Sits directly downstream of two up-counter stream sources and merges their streams onto one master port.
- Arbitrates round-robin only at packet boundaries: a granted source keeps the output until its tlast beat is accepted.
- Registered output stage. Per-source completed-packet counters for status.

Parameters:
- DataWidth, 32, width of s0/s1/m tdata.
- CntWidth, 16, width of each completed-packet counter; wraps modulo 2^CntWidth.

Ports:
- counter_clk  in  1  clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- s0_tdata  in  DataWidth  source 0 data.
- s0_tvalid  in  1  source 0 valid.
- s0_tlast  in  1  source 0 end of packet.
- s0_tready  out  1  source 0 ready.
- s1_tdata  in  DataWidth  source 1 data.
- s1_tvalid  in  1  source 1 valid.
- s1_tlast  in  1  source 1 end of packet.
- s1_tready  out  1  source 1 ready.
- m_tdata  out  DataWidth  merged data (registered).
- m_tvalid  out  1  merged valid (registered).
- m_tlast  out  1  merged end of packet (registered).
- m_tid  out  1  source index of the current m_* beat (registered).
- m_tready  in  1  downstream ready.
- pkt_cnt0  out  CntWidth  packets from s0 fully accepted.
- pkt_cnt1  out  CntWidth  packets from s1 fully accepted.

Behaviour:
- Reset values:
  - Outputs: m_tvalid=0, m_tdata=0, m_tlast=0, m_tid=0, pkt_cnt0=0, pkt_cnt1=0.
  - Internal: state=IDLE, last_grant=1, so s0 wins the first tie.
- load_en = !m_tvalid || m_tready.
  - The output register loads when empty or draining.
  - No combinational path from any s*_tvalid to m_tvalid.
- FSM states: IDLE, PASS0, PASS1.
- IDLE:
  - s0_tready=0, s1_tready=0.
  - Both sources valid: go to PASS(~last_grant).
  - Only one source valid: go to that source's PASS state.
  - Neither valid: stay in IDLE.
  - Grant decision is registered, so there is a one-cycle arbitration bubble.
  - The output register may still drain while in IDLE.
- PASSn:
  - sn_tready = load_en; the other source's tready = 0.
  - Beat accepted (sn_tvalid && sn_tready): m_tdata<=sn_tdata, m_tlast<=sn_tlast, m_tid<=n, m_tvalid<=1.
  - Accepted beat has tlast=1: go to IDLE, last_grant<=n, pkt_cntn<=pkt_cntn+1 on the same edge.
  - sn_tvalid low mid-packet: stay in PASSn and never switch source.
- Output drain: m_tready=1 with no beat loaded on the same edge sets m_tvalid<=0.
  - m_tdata, m_tlast, m_tid hold their last values.
- Stalls: while m_tvalid=1 and m_tready=0, m_tdata, m_tlast and m_tid stay stable.
- Latency: a beat accepted at edge k appears on m_* after edge k, i.e. one cycle.
- Throughput:
  - Full rate within a packet.
  - An N-beat packet occupies N+1 cycles, including the IDLE bubble.
- Counter wrap: at 2^CntWidth-1, the next increment gives 0.
- Single-beat packet (tvalid and tlast on the first beat): PASSn lasts one cycle, then IDLE.
- Reset asserted mid-packet:
  - All state clears immediately; the partial packet is truncated with no tlast emitted.
  - After reset release, arbitration restarts with s0 preferred.
- Source tvalid never gates its own tready: the AXI-Stream no-dependency rule is honoured.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'd0, PASS0=2'd1, PASS1=2'd2.
  - default DataWidth and CntWidth.
- One natural sub-module: axis_out_reg, the output register slice (data, last, id, valid, load_en).
  - The FSM, arbitration and counters stay in the top level.

Test Plan:
- Only s0 active, 4-beat packet 0,1,2,3 (tlast on 3), m_tready=1 -> m_tdata 0,1,2,3 on consecutive cycles starting one cycle after the first acceptance; m_tid=0; m_tlast only with 3; pkt_cnt0=1.
- Both sources continuously valid with 3-beat packets (s0 data 0..2, s1 data 10..12) -> output order 0,1,2,10,11,12,0,1,2; one idle cycle between packets; s1_tready=0 throughout s0's packet.
- Backpressure: m_tready held 0 for 3 cycles mid-packet -> m_tdata stable; s0_tready=0 for those cycles; no beat lost or duplicated; sequence intact after release.
- s0 drops tvalid for 2 cycles mid-packet while s1 is valid -> mux stays on s0; s1_tready=0 until s0's tlast is accepted; then s1 is granted.
- CntWidth=2, drive 5 single-beat packets on s1 only -> pkt_cnt1 sequence 1,2,3,0,1; each beat has m_tlast=1 and m_tid=1.
- Assert reset mid-packet on beat 2 of 4 -> m_tvalid=0 and pkt_cnt0=0 immediately; after release with both sources valid, s0 is granted first.
